com_send_ctrl: RTL
==================

# com_send_ctrl

Packet transmit sequencer between the console FSM and the link transmitter. On a send request it latches the bag type, RAM start address and byte count, frames them as a packet (sync header, type, length, RAM payload, checksum), streams the packet out through a byte valid/ready port, and returns a done handshake. It owns the read port of the shared 4 KiB sample/status RAM during a send.

## Interface
Parameters:
- `SYNC0`, 8'hAA: first sync byte.
- `SYNC1`, 8'h55: second sync byte.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `fs_send`  in  1  send request (level), held by the console until `fd_send` is seen.
- `fd_send`  out  1  send done, held while `fs_send` stays high.
- `send_btype`  in  4  bag type, sampled at request acceptance.
- `ram_addr_init`  in  12  first RAM byte address, sampled at request acceptance.
- `ram_dlen`  in  12  payload byte count (0..4095), sampled at request acceptance.
- `ram_rd_en`  out  1  RAM read strobe.
- `ram_rd_addr`  out  12  RAM read address.
- `ram_rd_data`  in  8  RAM data, valid the cycle after `ram_rd_en`.
- `tx_data`  out  8  packet byte.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  transmitter accepts the byte on `tx_valid & tx_ready`.

## Operation
- Packet order: SYNC0, SYNC1, {4'h0,btype}, {4'h0,dlen[11:8]}, dlen[7:0], dlen payload bytes from RAM[addr..addr+dlen-1], CSUM.
- CSUM is the 8-bit XOR of the type byte, both length bytes and all payload bytes. Sync bytes are excluded.
- RAM addresses increment modulo 4096 (0xFFF wraps to 0x000).
- States:
  - IDLE: `fs_send` high leads to LOAD.
  - LOAD: latch inputs, clear CSUM, go to HEAD0.
  - HEAD0, HEAD1, TYPE, LENH, LENL: each advances on acceptance.
  - LENL goes to DATA if dlen≠0, else to CSUM.
  - DATA: leaves for CSUM on acceptance of the last payload byte.
  - CSUM: advances to DONE on acceptance.
  - DONE: `fd_send`=1. Returns to IDLE when `fs_send`=0.
- `fs_send` dropping before DONE is ignored: the packet completes, and DONE lasts exactly one cycle.
- Payload prefetch:
  - Reads start during LENL.
  - At most 2 bytes are read but not yet accepted.
  - Exactly dlen reads are issued per packet; no read is issued outside LENL/DATA.
- Reset values: `fd_send`=0, `tx_valid`=0, `tx_data`=8'h00, `ram_rd_en`=0, `ram_rd_addr`=12'h000, state IDLE, prefetch buffer empty.
- A reset in any state aborts the packet immediately; no partial-packet recovery.

## Timing
- `fs_send` seen high in IDLE at edge N: LOAD at N+1, `tx_valid`=1 with SYNC0 from N+2.
- `tx_data` stays stable while `tx_valid & ~tx_ready`. `tx_valid` never drops before acceptance.
- With `tx_ready` held high:
  - one byte per cycle, including the LENL→DATA and DATA→CSUM boundaries;
  - a packet occupies dlen+6 consecutive valid cycles.
- After CSUM acceptance at edge M: `fd_send`=1 from M+1. It falls the cycle after `fs_send` is sampled low.
- RAM read latency is fixed at 1 cycle. The prefetch buffer captures `ram_rd_data` only on the cycle following `ram_rd_en`.
- Simultaneous buffer push (RAM return) and pop (tx accept) in the same cycle: occupancy unchanged, order preserved.

## Structure
- Shared package `com_pkg`: state encoding (one-hot, as in the console), SYNC0/SYNC1 defaults, the BAG_* type codes and RAM region base addresses, so that the console and this block agree.
- One sub-module, `byte_skid2`: 2-entry byte FIFO with push/pop, full and empty. DATA draws tx bytes from it; the read issuer gates `ram_rd_en` on occupancy plus in-flight reads < 2.
- Top level: FSM, address/remaining-count registers, CSUM accumulator, output mux.

## Test plan
- btype 4'h8, addr 12'hFCC, dlen 2, RAM[FCC]=12, RAM[FCD]=34, `tx_ready`=1 → AA 55 08 00 02 12 34 2C on 8 consecutive cycles; `fd_send` 1 cycle after last accept.
- btype 4'h9, dlen 0 → AA 55 09 00 00 09; zero `ram_rd_en` pulses.
- addr 12'hFFF, dlen 3, RAM[FFF]=01, RAM[000]=02, RAM[001]=03, btype 4'hA → read addresses FFF, 000, 001; payload 01 02 03, CSUM 0A^00^03^00 = 09.
- btype 4'hD, addr 12'h000, dlen 12'h202, `tx_ready` random 50% → exactly 514 reads, last address 12'h201; all bytes in order; `tx_data` stable across stalls; CSUM matches the model.
- `fs_send` held high after `fd_send` → `fd_send` stays 1 until `fs_send`=0, then falls next cycle; a second request then produces a fresh packet.
- `rst` asserted mid-DATA → all outputs at reset values at once; after release `tx_valid`=0 until a new `fs_send`.

Source files
------------

// File: rtl/com_pkg.sv
// Shared console/transmit definitions: FSM encoding, framing bytes, bag types, RAM map.
package com_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned TYPE_W = 4;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned LEN_W  = 12;

  localparam logic [BYTE_W-1:0] SYNC0_DEF = 8'hAA;
  localparam logic [BYTE_W-1:0] SYNC1_DEF = 8'h55;

  localparam logic [TYPE_W-1:0] BAG_STATUS = 4'h8;
  localparam logic [TYPE_W-1:0] BAG_ACK    = 4'h9;
  localparam logic [TYPE_W-1:0] BAG_SAMPLE = 4'hA;
  localparam logic [TYPE_W-1:0] BAG_DUMP   = 4'hD;

  localparam logic [ADDR_W-1:0] RAM_SAMPLE_BASE = 12'h000;
  localparam logic [ADDR_W-1:0] RAM_STATUS_BASE = 12'hFC0;

  // One-hot, shared with the console FSM
  typedef enum logic [9:0] {
    S_IDLE  = 10'b00_0000_0001,
    S_LOAD  = 10'b00_0000_0010,
    S_HEAD0 = 10'b00_0000_0100,
    S_HEAD1 = 10'b00_0000_1000,
    S_TYPE  = 10'b00_0001_0000,
    S_LENH  = 10'b00_0010_0000,
    S_LENL  = 10'b00_0100_0000,
    S_DATA  = 10'b00_1000_0000,
    S_CSUM  = 10'b01_0000_0000,
    S_DONE  = 10'b10_0000_0000
  } send_state_e;

endpackage

// File: rtl/byte_skid2.sv
// Two-entry byte FIFO; when empty, a same-cycle push falls straight through to dout_c.
module byte_skid2
  import com_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [BYTE_W-1:0] din,
  input  logic              pop,
  output logic [BYTE_W-1:0] dout_c,
  output logic              avail_c,
  output logic              full_c,
  output logic              empty_c
);

  logic [BYTE_W-1:0] mem_q [2];
  logic [BYTE_W-1:0] mem_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              deq, bypass, store, wr_ptr;

  always_comb begin
    empty_c  = (count_q == 2'd0);
    full_c   = (count_q == 2'd2);
    avail_c  = !empty_c || push;
    dout_c   = empty_c ? din : mem_q[rd_ptr_q];
    deq      = pop && !empty_c;
    bypass   = pop && empty_c && push;
    store    = push && !bypass && (!full_c || deq);
    wr_ptr   = rd_ptr_q ^ count_q[0];
    mem_d    = mem_q;
    if (store) mem_d[wr_ptr] = din;
    rd_ptr_d = rd_ptr_q ^ deq;
    count_d  = count_q + 2'(store) - 2'(deq);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/com_send_ctrl.sv
// Packet transmit sequencer: frames a RAM region as SYNC/TYPE/LEN/payload/CSUM
// and streams it over a byte valid/ready port.
module com_send_ctrl
  import com_pkg::*;
#(
  parameter logic [BYTE_W-1:0] SYNC0 = SYNC0_DEF,
  parameter logic [BYTE_W-1:0] SYNC1 = SYNC1_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fs_send,
  output logic              fd_send,
  input  logic [TYPE_W-1:0] send_btype,
  input  logic [ADDR_W-1:0] ram_addr_init,
  input  logic [LEN_W-1:0]  ram_dlen,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [BYTE_W-1:0] ram_rd_data,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  send_state_e       state_q, state_d;
  logic [TYPE_W-1:0] btype_q, btype_d;
  logic [LEN_W-1:0]  dlen_q, dlen_d;
  logic [LEN_W-1:0]  issue_left_q, issue_left_d;
  logic [LEN_W-1:0]  pay_left_q, pay_left_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [BYTE_W-1:0] csum_q, csum_d;
  logic              rd_en_q, rd_en_d;
  logic              rd_vld_q, rd_vld_d;
  logic              fd_send_q, fd_send_d;

  logic              accept, skid_pop;
  logic [BYTE_W-1:0] skid_dout;
  logic              skid_avail, skid_full, skid_empty;
  logic [1:0]        occ;
  logic [2:0]        outstanding, out_after;
  logic              rd_issue;

  byte_skid2 u_skid (
    .clk     (clk),
    .rst_n   (rst),
    .push    (rd_vld_q),
    .din     (ram_rd_data),
    .pop     (skid_pop),
    .dout_c  (skid_dout),
    .avail_c (skid_avail),
    .full_c  (skid_full),
    .empty_c (skid_empty)
  );

  // Output byte mux over the latched header fields, skid head and checksum
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = '0;
    unique case (state_q)
      S_HEAD0: begin tx_valid = 1'b1; tx_data = SYNC0; end
      S_HEAD1: begin tx_valid = 1'b1; tx_data = SYNC1; end
      S_TYPE:  begin tx_valid = 1'b1; tx_data = {4'h0, btype_q}; end
      S_LENH:  begin tx_valid = 1'b1; tx_data = {4'h0, dlen_q[11:8]}; end
      S_LENL:  begin tx_valid = 1'b1; tx_data = dlen_q[7:0]; end
      S_DATA:  begin tx_valid = skid_avail; tx_data = skid_avail ? skid_dout : '0; end
      S_CSUM:  begin tx_valid = 1'b1; tx_data = csum_q; end
      default: ;
    endcase
  end

  assign accept   = tx_valid && tx_ready;
  assign skid_pop = accept && (state_q == S_DATA);

  always_comb begin
    state_d      = state_q;
    btype_d      = btype_q;
    dlen_d       = dlen_q;
    issue_left_d = issue_left_q;
    pay_left_d   = pay_left_q;
    next_addr_d  = next_addr_q;
    rd_addr_d    = rd_addr_q;
    csum_d       = csum_q;
    rd_vld_d     = rd_en_q;

    unique case (state_q)
      S_IDLE:  if (fs_send) state_d = S_LOAD;
      S_LOAD: begin
        btype_d      = send_btype;
        dlen_d       = ram_dlen;
        issue_left_d = ram_dlen;
        pay_left_d   = ram_dlen;
        next_addr_d  = ram_addr_init;
        csum_d       = '0;
        state_d      = S_HEAD0;
      end
      S_HEAD0: if (accept) state_d = S_HEAD1;
      S_HEAD1: if (accept) state_d = S_TYPE;
      S_TYPE: if (accept) begin
        csum_d  = csum_q ^ tx_data;
        state_d = S_LENH;
      end
      S_LENH: if (accept) begin
        csum_d  = csum_q ^ tx_data;
        state_d = S_LENL;
      end
      S_LENL: if (accept) begin
        csum_d  = csum_q ^ tx_data;
        state_d = (dlen_q != '0) ? S_DATA : S_CSUM;
      end
      S_DATA: if (accept) begin
        csum_d     = csum_q ^ tx_data;
        pay_left_d = pay_left_q - LEN_W'(1);
        if (pay_left_q == LEN_W'(1)) state_d = S_CSUM;
      end
      S_CSUM:  if (accept) state_d = S_DONE;
      S_DONE:  if (!fs_send) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Keep at most two payload bytes read but not yet accepted
    occ         = skid_full ? 2'd2 : (skid_empty ? 2'd0 : 2'd1);
    outstanding = 3'(occ) + 3'(rd_vld_q) + 3'(rd_en_q);
    out_after   = outstanding - 3'(skid_pop);
    rd_issue    = ((state_d == S_LENL) || (state_d == S_DATA)) &&
                  (issue_left_q != '0) && (out_after < 3'd2);
    rd_en_d     = rd_issue;
    if (rd_issue) begin
      rd_addr_d    = next_addr_q;
      next_addr_d  = next_addr_q + ADDR_W'(1);
      issue_left_d = issue_left_q - LEN_W'(1);
    end

    fd_send_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      btype_q      <= '0;
      dlen_q       <= '0;
      issue_left_q <= '0;
      pay_left_q   <= '0;
      next_addr_q  <= '0;
      rd_addr_q    <= '0;
      csum_q       <= '0;
      rd_en_q      <= 1'b0;
      rd_vld_q     <= 1'b0;
      fd_send_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      btype_q      <= btype_d;
      dlen_q       <= dlen_d;
      issue_left_q <= issue_left_d;
      pay_left_q   <= pay_left_d;
      next_addr_q  <= next_addr_d;
      rd_addr_q    <= rd_addr_d;
      csum_q       <= csum_d;
      rd_en_q      <= rd_en_d;
      rd_vld_q     <= rd_vld_d;
      fd_send_q    <= fd_send_d;
    end
  end

  assign fd_send     = fd_send_q;
  assign ram_rd_en   = rd_en_q;
  assign ram_rd_addr = rd_addr_q;

endmodule
